// File: rtl/temp_scan_ctrl_if.sv
// Shared sensor read port: req/sel out, ack/data back.
// Data is valid in the same cycle as ack.
interface temp_scan_ctrl_if #(
  parameter int W = 8
);
  logic         sens_req;
  logic [1:0]   sens_sel;
  logic         sens_ack;
  logic [W-1:0] sens_data;

  modport master (
    output sens_req,
    output sens_sel,
    input  sens_ack,
    input  sens_data
  );

  modport slave (
    input  sens_req,
    input  sens_sel,
    output sens_ack,
    output sens_data
  );
endinterface

// File: rtl/temp_scan_ctrl.sv
// Periodic 4-sensor temperature scan: average, threshold,
// debounced over-temp flag and sticky ack-timeout fault.
module temp_scan_ctrl #(
  parameter int W       = 8,
  parameter int PERIOD  = 100,
  parameter int TIMEOUT = 16,
  parameter int HOT_CNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [W-1:0]     temp_compare,
  temp_scan_ctrl_if.master sens,
  output logic [W-1:0]     avg,
  output logic             avg_valid,
  output logic             tooHot,
  output logic             busy,
  output logic             fault
);

  localparam int TW = $clog2(PERIOD);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HOT_CNT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CALC
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [W+1:0]  sum_q, sum_d;
  logic          req_q, req_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [W-1:0]  avg_q, avg_d;
  logic          vld_q, vld_d;
  logic          hot_q, hot_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          fault_q, fault_d;

  logic          tick;
  logic [W-1:0]  avg_n;
  logic          hot_scan;
  logic [HW-1:0] hcnt_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      sum_q   <= '0;
      req_q   <= 1'b0;
      tcnt_q  <= '0;
      timer_q <= TW'(PERIOD - 1);
      avg_q   <= '0;
      vld_q   <= 1'b0;
      hot_q   <= 1'b0;
      hcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      sum_q   <= sum_d;
      req_q   <= req_d;
      tcnt_q  <= tcnt_d;
      timer_q <= timer_d;
      avg_q   <= avg_d;
      vld_q   <= vld_d;
      hot_q   <= hot_d;
      hcnt_q  <= hcnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    sum_d    = sum_q;
    req_d    = req_q;
    tcnt_d   = tcnt_q;
    avg_d    = avg_q;
    vld_d    = 1'b0;
    hot_d    = hot_q;
    hcnt_d   = hcnt_q;
    fault_d  = fault_q;

    tick     = enable && (timer_q == '0);
    timer_d  = (!enable || tick) ? TW'(PERIOD - 1)
                                 : timer_q - TW'(1);

    avg_n    = sum_q[W+1:2];
    hot_scan = avg_n > temp_compare;
    hcnt_inc = (hcnt_q == HW'(HOT_CNT)) ? hcnt_q
                                        : hcnt_q + HW'(1);

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = REQ;
          sel_d   = '0;
          sum_d   = '0;
          req_d   = 1'b1;
          tcnt_d  = '0;
        end
      end
      REQ: begin
        // req low here is the mandatory gap between reads
        if (!req_q) begin
          req_d  = 1'b1;
          tcnt_d = '0;
        end else if (sens.sens_ack) begin
          sum_d = sum_q + {2'b00, sens.sens_data};
          req_d = 1'b0;
          if (sel_q == 2'd3) state_d = CALC;
          else sel_d = sel_q + 2'd1;
        end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + CW'(1);
        end
      end
      CALC: begin
        avg_d   = avg_n;
        vld_d   = 1'b1;
        state_d = IDLE;
        if (hot_scan) begin
          hcnt_d = hcnt_inc;
          hot_d  = (hcnt_inc == HW'(HOT_CNT));
        end else begin
          hcnt_d = '0;
          hot_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sens.sens_req = req_q;
  assign sens.sens_sel = sel_q;
  assign avg           = avg_q;
  assign avg_valid     = vld_q;
  assign tooHot        = hot_q;
  assign busy          = (state_q != IDLE);
  assign fault         = fault_q;

endmodule
